// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - CSR addresses, IRQ causes, write masks and reset constants for csr_unit
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    localparam logic [31:0] MIE_MASK           = 32'hFFFF_0888;
    localparam logic [31:0] MIP_SW_MASK        = 32'hFFFF_0000;
    localparam logic [31:0] IRQ_MASK           = 32'h0000_0888;
    localparam logic [31:0] MCOUNTINHIBIT_MASK = 32'h0000_0005;
    localparam logic [31:0] MISA_VALUE         = 32'h4000_0100;
    localparam logic [31:0] MSTATUS_RESET      = 32'h0000_1800;

    // Only canonical causes are accepted; anything with stray middle bits is rejected.
    function automatic logic mcause_legal(input logic [31:0] v);
        if (v[30:4] != 27'd0) return 1'b0;
        if (v[31]) return (v[3:0] inside {4'd1, 4'd3, 4'd5, 4'd7, 4'd9, 4'd11});
        return !(v[3:0] == 4'd10 || v[3:0] == 4'd14);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit wrapping counter with per-half write override
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (wr_lo || wr_hi) begin
            if (wr_lo) value[31:0]  <= wdata;
            if (wr_hi) value[63:32] <= wdata;
        end else if (en) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR unit; counters enabled by CSR_COUNTERS_EN
module csr_unit
    import csr_pkg::*;
#(
    parameter int          NREAD   = 2,
    parameter logic [31:0] HART_ID = 32'd0
) (
    input  logic                 ctrl_clk,
    input  logic                 ctrl_reset_n,
    input  logic [NREAD*12-1:0]  raddr,
    output logic [NREAD*32-1:0]  rdata,
    output logic [NREAD-1:0]     rillegal,
    input  logic                 wen,
    input  logic [11:0]          waddr,
    input  logic [31:0]          wdata,
    input  logic [31:0]          trap_pc,
    input  logic [4:0]           trap_info,
    input  logic                 ctrl_trap,
    input  logic                 ctrl_mret,
    input  logic                 retire,
    input  logic                 irq_m_soft,
    input  logic                 irq_m_timer,
    input  logic                 irq_m_ext,
    output logic                 irq_req,
    output logic [3:0]           irq_cause,
    output logic [31:0]          trap_target,
    output logic                 ctrl_mie,
    output logic                 ctrl_mpie
);

    logic        st_mie, st_mpie, msip, mtip, meip;
    logic [31:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
    logic [15:0] mip_hi;
    logic [31:0] mstatus_rd, mip_rd, pend, wlegal, cur;
    logic        wr, ill;

    assign wr         = wen && !ctrl_trap;
    assign mstatus_rd = MSTATUS_RESET | {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mip_rd     = {mip_hi, 4'b0, meip, 3'b0, mtip, 3'b0, msip, 3'b0};
    assign ctrl_mie   = st_mie;
    assign ctrl_mpie  = st_mpie;

`ifdef CSR_COUNTERS_EN
    logic        inh_cy, inh_ir;
    logic [63:0] mcycle, minstret;

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            inh_cy <= 1'b0;
            inh_ir <= 1'b0;
        end else if (wr && waddr == CSR_MCOUNTINHIBIT) begin
            inh_cy <= wdata[0];
            inh_ir <= wdata[2];
        end
    end

    csr_counter64 u_mcycle (
        .clk(ctrl_clk), .rst_n(ctrl_reset_n), .en(!inh_cy),
        .wr_lo(wr && waddr == CSR_MCYCLE), .wr_hi(wr && waddr == CSR_MCYCLEH),
        .wdata(wdata), .value(mcycle)
    );

    csr_counter64 u_minstret (
        .clk(ctrl_clk), .rst_n(ctrl_reset_n), .en(retire && !inh_ir),
        .wr_lo(wr && waddr == CSR_MINSTRET), .wr_hi(wr && waddr == CSR_MINSTRETH),
        .wdata(wdata), .value(minstret)
    );
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            msip       <= 1'b0;
            mtip       <= 1'b0;
            meip       <= 1'b0;
            mie_r      <= '0;
            mtvec_r    <= '0;
            mscratch_r <= '0;
            mepc_r     <= '0;
            mcause_r   <= '0;
            mtval_r    <= '0;
            mip_hi     <= '0;
        end else begin
            msip <= irq_m_soft;
            mtip <= irq_m_timer;
            meip <= irq_m_ext;
            if (ctrl_trap) begin
                if (ctrl_mret) begin
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b0;
                end else begin
                    st_mpie  <= st_mie;
                    st_mie   <= 1'b0;
                    mepc_r   <= {trap_pc[31:2], 2'b00};
                    mcause_r <= {trap_info[4], 27'b0, trap_info[3:0]};
                end
            end else if (wen) begin
                case (waddr)
                    CSR_MSTATUS: begin
                        st_mie  <= wdata[3];
                        st_mpie <= wdata[7];
                    end
                    CSR_MIE:      mie_r      <= wdata & MIE_MASK;
                    CSR_MTVEC:    if (wdata[1:0] < 2'd2) mtvec_r <= wdata;
                    CSR_MSCRATCH: mscratch_r <= wdata;
                    CSR_MEPC:     mepc_r     <= {wdata[31:2], 2'b00};
                    CSR_MCAUSE:   if (mcause_legal(wdata)) mcause_r <= wdata;
                    CSR_MTVAL:    mtval_r    <= wdata;
                    CSR_MIP:      mip_hi     <= wdata[31:16];
                    default: ;
                endcase
            end
        end
    end

    // Value the addressed CSR will hold after this write; feeds the read bypass.
    always_comb begin
        wlegal = '0;
        case (waddr)
            CSR_MSTATUS:  wlegal = MSTATUS_RESET | {24'b0, wdata[7], 3'b0, wdata[3], 3'b0};
            CSR_MISA:     wlegal = MISA_VALUE;
            CSR_MIE:      wlegal = wdata & MIE_MASK;
            CSR_MTVEC:    wlegal = (wdata[1:0] < 2'd2) ? wdata : mtvec_r;
            CSR_MSCRATCH: wlegal = wdata;
            CSR_MEPC:     wlegal = {wdata[31:2], 2'b00};
            CSR_MCAUSE:   wlegal = mcause_legal(wdata) ? wdata : mcause_r;
            CSR_MTVAL:    wlegal = wdata;
            CSR_MIP:      wlegal = (wdata & MIP_SW_MASK) | (mip_rd & ~MIP_SW_MASK);
            CSR_MHARTID:  wlegal = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCOUNTINHIBIT: wlegal = wdata & MCOUNTINHIBIT_MASK;
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: wlegal = wdata;
`endif
            default:      wlegal = '0;
        endcase
    end

    always_comb begin
        rdata    = '0;
        rillegal = '0;
        cur      = '0;
        ill      = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            cur = '0;
            ill = 1'b0;
            case (raddr[i*12 +: 12])
                CSR_MSTATUS:  cur = mstatus_rd;
                CSR_MISA:     cur = MISA_VALUE;
                CSR_MIE:      cur = mie_r;
                CSR_MTVEC:    cur = mtvec_r;
                CSR_MSCRATCH: cur = mscratch_r;
                CSR_MEPC:     cur = mepc_r;
                CSR_MCAUSE:   cur = mcause_r;
                CSR_MTVAL:    cur = mtval_r;
                CSR_MIP:      cur = mip_rd;
                CSR_MHARTID:  cur = HART_ID;
`ifdef CSR_COUNTERS_EN
                CSR_MCOUNTINHIBIT: cur = {29'b0, inh_ir, 1'b0, inh_cy};
                CSR_MCYCLE:    cur = mcycle[31:0];
                CSR_MCYCLEH:   cur = mcycle[63:32];
                CSR_MINSTRET:  cur = minstret[31:0];
                CSR_MINSTRETH: cur = minstret[63:32];
`endif
                default:      ill = 1'b1;
            endcase
            rdata[i*32 +: 32] = (wr && waddr == raddr[i*12 +: 12]) ? wlegal : cur;
            rillegal[i]       = ill;
        end
    end

    assign pend    = mip_rd & mie_r & IRQ_MASK;
    assign irq_req = st_mie && (pend != 32'd0);

    always_comb begin
        if (pend[11])     irq_cause = IRQ_MEI;
        else if (pend[3]) irq_cause = IRQ_MSI;
        else if (pend[7]) irq_cause = IRQ_MTI;
        else              irq_cause = 4'd0;
    end

    always_comb begin
        trap_target = {mtvec_r[31:2], 2'b00};
        if (mtvec_r[1:0] == 2'd1 && trap_info[4])
            trap_target = {mtvec_r[31:2], 2'b00} + {26'b0, trap_info[3:0], 2'b00};
    end

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - self-checking bench for csr_unit
module tb_csr_unit;

    logic        ctrl_clk = 1'b0;
    logic        ctrl_reset_n;
    logic [23:0] raddr;
    logic [63:0] rdata;
    logic [1:0]  rillegal;
    logic        wen;
    logic [11:0] waddr;
    logic [31:0] wdata, trap_pc, trap_target;
    logic [4:0]  trap_info;
    logic        ctrl_trap, ctrl_mret, retire;
    logic        irq_m_soft, irq_m_timer, irq_m_ext;
    logic        irq_req, ctrl_mie, ctrl_mpie;
    logic [3:0]  irq_cause;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];

    csr_unit #(.NREAD(2), .HART_ID(32'd0)) dut (
        .ctrl_clk(ctrl_clk), .ctrl_reset_n(ctrl_reset_n),
        .raddr(raddr), .rdata(rdata), .rillegal(rillegal),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .trap_pc(trap_pc), .trap_info(trap_info),
        .ctrl_trap(ctrl_trap), .ctrl_mret(ctrl_mret), .retire(retire),
        .irq_m_soft(irq_m_soft), .irq_m_timer(irq_m_timer), .irq_m_ext(irq_m_ext),
        .irq_req(irq_req), .irq_cause(irq_cause), .trap_target(trap_target),
        .ctrl_mie(ctrl_mie), .ctrl_mpie(ctrl_mpie)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [31:0] exp);
        sbq.push_back('{name, exp});
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_t e;
        if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: got %h expected an entry", act);
        end else begin
            e = sbq.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    task automatic tick();
        @(posedge ctrl_clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        tick();
        wen = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctrl_reset_n = 1'b0;
        raddr = {12'h301, 12'h300};
        wen = 1'b0; waddr = '0; wdata = '0;
        trap_pc = '0; trap_info = '0; ctrl_trap = 1'b0; ctrl_mret = 1'b0; retire = 1'b0;
        irq_m_soft = 1'b0; irq_m_timer = 1'b0; irq_m_ext = 1'b0;

        vecs.push_back('{12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b0});
        vecs.push_back('{12'h301, 32'h0000_0000, 32'h4000_0100, 1'b0});
        vecs.push_back('{12'h304, 32'hFFFF_FFFF, 32'hFFFF_0888, 1'b0});
        vecs.push_back('{12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{12'h341, 32'h0000_1237, 32'h0000_1234, 1'b0});
        vecs.push_back('{12'h342, 32'h8000_000B, 32'h8000_000B, 1'b0});
        vecs.push_back('{12'h342, 32'h0000_000A, 32'h8000_000B, 1'b0});
        vecs.push_back('{12'h342, 32'h8000_0002, 32'h8000_000B, 1'b0});
        vecs.push_back('{12'h343, 32'h1234_5678, 32'h1234_5678, 1'b0});
        vecs.push_back('{12'h344, 32'hFFFF_FFFF, 32'hFFFF_0000, 1'b0});
        vecs.push_back('{12'hF14, 32'h0000_0005, 32'h0000_0000, 1'b0});
        vecs.push_back('{12'h123, 32'h0000_0055, 32'h0000_0000, 1'b1});
        vecs.push_back('{12'h305, 32'h0000_1002, 32'h0000_0000, 1'b0});
        vecs.push_back('{12'h305, 32'h0000_1001, 32'h0000_1001, 1'b0});
        vecs.push_back('{12'h305, 32'h0000_1002, 32'h0000_1001, 1'b0});
`ifdef CSR_COUNTERS_EN
        vecs.push_back('{12'h320, 32'hFFFF_FFFF, 32'h0000_0005, 1'b0});
        vecs.push_back('{12'h320, 32'h0000_0000, 32'h0000_0000, 1'b0});
`else
        vecs.push_back('{12'h320, 32'h0000_0005, 32'h0000_0000, 1'b1});
        vecs.push_back('{12'hB00, 32'h0000_0001, 32'h0000_0000, 1'b1});
`endif

        #12;
        check("reset_mstatus", rdata[31:0], 32'h0000_1800);
        check("reset_misa", rdata[63:32], 32'h4000_0100);
        check("reset_irq_req", {31'b0, irq_req}, 32'd0);
        check("reset_irq_cause", {28'b0, irq_cause}, 32'd0);
        check("reset_mie_mpie", {30'b0, ctrl_mpie, ctrl_mie}, 32'd0);
        @(negedge ctrl_clk);
        ctrl_reset_n = 1'b1;
        tick();

        foreach (vecs[k]) begin
            wen = 1'b1; waddr = vecs[k].addr; wdata = vecs[k].wdata;
            raddr = {vecs[k].addr, vecs[k].addr};
            sb_push($sformatf("bypass_%0d_%h", k, vecs[k].addr), vecs[k].exp);
            #1;
            sb_pop(rdata[31:0]);
            check($sformatf("rillegal_%0d_%h", k, vecs[k].addr), {31'b0, rillegal[0]}, {31'b0, vecs[k].ill});
            tick();
            wen = 1'b0;
            sb_push($sformatf("stored_%0d_%h", k, vecs[k].addr), vecs[k].exp);
            #1;
            sb_pop(rdata[63:32]);
        end

        // mtvec=0x1001 (vectored): interrupt 7 offsets by 0x1C, exceptions go to base
        trap_info = 5'b10111; #1;
        check("target_vectored_irq", trap_target, 32'h0000_101C);
        trap_info = 5'b00111; #1;
        check("target_vectored_exc", trap_target, 32'h0000_1000);

        // trap beats a same-cycle mepc write; bypass must be off
        ctrl_trap = 1'b1; trap_pc = 32'h80; trap_info = 5'b00010;
        wen = 1'b1; waddr = 12'h341; wdata = 32'h5557; raddr = {12'h342, 12'h341};
        #1;
        check("no_bypass_in_trap", rdata[31:0], 32'h0000_1234);
        tick();
        ctrl_trap = 1'b0; wen = 1'b0; #1;
        check("trap_mie", {31'b0, ctrl_mie}, 32'd0);
        check("trap_mpie", {31'b0, ctrl_mpie}, 32'd1);
        check("trap_mepc", rdata[31:0], 32'h0000_0080);
        check("trap_mcause", rdata[63:32], 32'h0000_0002);
        ctrl_trap = 1'b1; ctrl_mret = 1'b1;
        tick();
        ctrl_trap = 1'b0; ctrl_mret = 1'b0; raddr = {12'h341, 12'h300}; #1;
        check("mret_mstatus", rdata[31:0], 32'h0000_1808);
        check("mret_mepc_kept", rdata[63:32], 32'h0000_0080);

        csr_write(12'h305, 32'h0000_2000);
        trap_info = 5'b10111; #1;
        check("target_direct", trap_target, 32'h0000_2000);

        // interrupts: MIE=1 after mret
        csr_write(12'h304, 32'h0000_0888);
        raddr = {12'h300, 12'h344};
        irq_m_soft = 1'b1; irq_m_timer = 1'b1; irq_m_ext = 1'b1; #1;
        check("irq_not_yet", {31'b0, irq_req}, 32'd0);
        tick();
        check("irq_req_all", {31'b0, irq_req}, 32'd1);
        check("irq_cause_all", {28'b0, irq_cause}, 32'd11);
        check("mip_read", rdata[31:0], 32'hFFFF_0888);
        irq_m_ext = 1'b0;
        tick();
        check("irq_cause_no_ext", {28'b0, irq_cause}, 32'd3);
        irq_m_soft = 1'b0;
        tick();
        check("irq_cause_timer", {28'b0, irq_cause}, 32'd7);
        csr_write(12'h300, 32'h0);
        #1;
        check("irq_masked_by_mie", {31'b0, irq_req}, 32'd0);
        irq_m_timer = 1'b0;
        tick();
        check("irq_cause_none", {28'b0, irq_cause}, 32'd0);

`ifdef CSR_COUNTERS_EN
        csr_write(12'hB00, 32'hFFFF_FFFF);
        csr_write(12'hB80, 32'hFFFF_FFFF);
        raddr = {12'hB80, 12'hB00};
        tick();
        check("mcycle_wrap_lo", rdata[31:0], 32'd0);
        check("mcycle_wrap_hi", rdata[63:32], 32'd0);
        csr_write(12'hB02, 32'd5);
        csr_write(12'hB82, 32'd0);
        raddr = {12'hB82, 12'hB02};
        #1;
        check("minstret_idle", rdata[31:0], 32'd5);
        retire = 1'b1;
        tick(); tick();
        check("minstret_count", rdata[31:0], 32'd7);
        csr_write(12'h320, 32'h4);
        #1;
        check("minstret_inhibit_edge", rdata[31:0], 32'd8);
        tick(); tick();
        retire = 1'b0;
        check("minstret_held", rdata[31:0], 32'd8);
`endif

        // asynchronous reset in mid-cycle
        csr_write(12'h341, 32'h0000_4444);
        raddr = {12'h300, 12'h341};
        #2;
        ctrl_reset_n = 1'b0;
        #1;
        check("async_rst_mepc", rdata[31:0], 32'd0);
        check("async_rst_mstatus", rdata[63:32], 32'h0000_1800);
        @(negedge ctrl_clk);
        ctrl_reset_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
